// File: rtl/regfile_param.sv
// Parametrised register file: NUM_REGS x DATA_W, combinational read ports, internal PC
// on the top index, and a per-register busy scoreboard. Optional bypass: REGFILE_BYPASS_EN.
module regfile_param #(
   parameter int                DATA_W   = 32,
   parameter int                NUM_REGS = 16,
   parameter int                NUM_RD   = 3,
   parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4),
   parameter logic [DATA_W-1:0] PC_RESET = '0,
   localparam int               AW       = $clog2(NUM_REGS)
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [DATA_W-1:0]        PW,
   input  logic [AW-1:0]            RW,
   input  logic                     LE,
   input  logic [NUM_RD*AW-1:0]     RADDR,
   output logic [NUM_RD*DATA_W-1:0] RDATA,
   output logic [NUM_RD-1:0]        RBUSY,
   input  logic                     PC_LD,
   input  logic [DATA_W-1:0]        PC_IN,
   input  logic                     PC_EN,
   output logic [DATA_W-1:0]        PC,
   input  logic                     RSV_EN,
   input  logic [AW-1:0]            RSV_ADDR,
   output logic [NUM_REGS-1:0]      BUSY
);

   localparam logic [AW-1:0] PC_IDX = AW'(NUM_REGS - 1);

   logic [DATA_W-1:0]   r_regs [NUM_REGS-1];
   logic [DATA_W-1:0]   r_pc;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_rsv_dec;
   logic [NUM_REGS-1:0] w_wr_dec;
   logic                w_wr_pc;

   assign w_wr_pc   = LE && (RW == PC_IDX);
   assign w_rsv_dec = RSV_EN ? (NUM_REGS'(1) << RSV_ADDR) : '0;
   assign w_wr_dec  = LE     ? (NUM_REGS'(1) << RW)       : '0;

   // NOTE: the general registers must read 0 straight out of reset, so the array is
   // reset explicitly; that keeps it in flops rather than letting it map to a RAM macro.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            r_regs[i] <= '0;
         end
      end else if (LE && (RW != PC_IDX)) begin
         r_regs[RW] <= PW;
      end
   end

   // NOTE: state updates are non-blocking so every block samples pre-edge values,
   // independent of the order the simulator evaluates them in.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pc <= PC_RESET;
      end else if (PC_LD) begin
         r_pc <= PC_IN;
      end else if (w_wr_pc) begin
         r_pc <= PW;
      end else if (PC_EN) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   // Reserve is OR-ed in after the write clear, so a same-cycle reserve wins.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_wr_dec) | w_rsv_dec;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]     w_addr;
      logic [DATA_W-1:0] w_stored;
      logic              w_byp;

      assign w_addr   = RADDR[k*AW +: AW];
      assign w_stored = (w_addr == PC_IDX) ? r_pc : r_regs[w_addr];
`ifdef REGFILE_BYPASS_EN
      assign w_byp    = LE && (w_addr == RW);
`else
      assign w_byp    = 1'b0;
`endif
      assign RDATA[k*DATA_W +: DATA_W] = w_byp ? PW : w_stored;
      assign RBUSY[k]                  = ~w_byp & r_busy[w_addr];
   end

   assign PC   = r_pc;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default 16x32x3 instance plus a 8x16x2 sweep instance.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;

   logic [31:0] pw;
   logic [3:0]  rw;
   logic        le;
   logic [11:0] raddr;
   logic [95:0] rdata;
   logic [2:0]  rbusy;
   logic        pc_ld;
   logic [31:0] pc_in;
   logic        pc_en;
   logic [31:0] pc;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic [15:0] busy;

   logic [15:0] b_pw;
   logic [2:0]  b_rw;
   logic        b_le;
   logic [5:0]  b_raddr;
   logic [31:0] b_rdata;
   logic [1:0]  b_rbusy;
   logic        b_pc_ld;
   logic [15:0] b_pc_in;
   logic        b_pc_en;
   logic [15:0] b_pc;
   logic        b_rsv_en;
   logic [2:0]  b_rsv_addr;
   logic [7:0]  b_busy;

   regfile_param u_dut (
      .CLK(CLK), .RESET(RESET), .PW(pw), .RW(rw), .LE(le), .RADDR(raddr),
      .RDATA(rdata), .RBUSY(rbusy), .PC_LD(pc_ld), .PC_IN(pc_in), .PC_EN(pc_en),
      .PC(pc), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .BUSY(busy)
   );

   regfile_param #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) u_dut_b (
      .CLK(CLK), .RESET(RESET), .PW(b_pw), .RW(b_rw), .LE(b_le), .RADDR(b_raddr),
      .RDATA(b_rdata), .RBUSY(b_rbusy), .PC_LD(b_pc_ld), .PC_IN(b_pc_in), .PC_EN(b_pc_en),
      .PC(b_pc), .RSV_EN(b_rsv_en), .RSV_ADDR(b_rsv_addr), .BUSY(b_busy)
   );

   always #5 CLK = ~CLK;

   typedef enum {S_RD0, S_RD1, S_RD2, S_BUSY, S_RBUSY, S_PC,
                 S_B_RD0, S_B_RD1, S_B_PC, S_B_BUSY} sel_t;

   typedef struct {
      sel_t        sel;
      string       name;
      logic [63:0] exp;
   } exp_t;

   typedef struct {
      logic        le;
      logic [3:0]  rw;
      logic [31:0] pw;
      logic        rsv;
      logic [3:0]  rsv_a;
      logic [3:0]  ra0, ra1, ra2;
      logic [31:0] e0, e1, e2;
      logic [15:0] ebusy;
      logic [2:0]  erbusy;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[11];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [63:0] actual(input sel_t s);
      case (s)
         S_RD0:    return 64'(rdata[31:0]);
         S_RD1:    return 64'(rdata[63:32]);
         S_RD2:    return 64'(rdata[95:64]);
         S_BUSY:   return 64'(busy);
         S_RBUSY:  return 64'(rbusy);
         S_PC:     return 64'(pc);
         S_B_RD0:  return 64'(b_rdata[15:0]);
         S_B_RD1:  return 64'(b_rdata[31:16]);
         S_B_PC:   return 64'(b_pc);
         S_B_BUSY: return 64'(b_busy);
         default:  return '0;
      endcase
   endfunction

   task automatic push(input sel_t s, input string name, input logic [63:0] e);
      exp_t t;
      t.sel  = s;
      t.name = name;
      t.exp  = e;
      sb_q.push_back(t);
   endtask

   task automatic drain();
      exp_t t;
      while (sb_q.size() > 0) begin
         t = sb_q.pop_front();
         check(t.name, actual(t.sel), t.exp);
      end
   endtask

   task automatic set_ra(input int k, input int a);
      raddr[k*4 +: 4] = 4'(a);
   endtask

   // One edge: pulse inputs drop right after it, then queued expectations are compared.
   task automatic cycle();
      @(posedge CLK);
      #1;
      le = 1'b0; rsv_en = 1'b0; pc_ld = 1'b0; pc_en = 1'b0;
      b_le = 1'b0; b_rsv_en = 1'b0; b_pc_ld = 1'b0; b_pc_en = 1'b0;
      #1;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_pre;

      vecs[0]  = '{1'b1, 4'd4,  32'h4444_4444, 1'b0, 4'd0, 4'd4,  4'd3,  4'd0,
                   32'h4444_4444, 32'hDEAD_BEEF, 32'h0,         16'h0000, 3'b000};
      vecs[1]  = '{1'b1, 4'd1,  32'h1111_1111, 1'b0, 4'd0, 4'd1,  4'd3,  4'd2,
                   32'h1111_1111, 32'hDEAD_BEEF, 32'h0,         16'h0000, 3'b000};
      vecs[2]  = '{1'b1, 4'd14, 32'hA5A5_5A5A, 1'b0, 4'd0, 4'd14, 4'd1,  4'd0,
                   32'hA5A5_5A5A, 32'h1111_1111, 32'h0,         16'h0000, 3'b000};
      vecs[3]  = '{1'b1, 4'd0,  32'hCAFE_F00D, 1'b0, 4'd0, 4'd0,  4'd14, 4'd3,
                   32'hCAFE_F00D, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 16'h0000, 3'b000};
      vecs[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd5, 4'd5,  4'd5,  4'd3,
                   32'h0,         32'h0,         32'hDEAD_BEEF, 16'h0020, 3'b011};
      vecs[5]  = '{1'b1, 4'd5,  32'h0000_0055, 1'b0, 4'd0, 4'd5,  4'd7,  4'd3,
                   32'h0000_0055, 32'h0,         32'hDEAD_BEEF, 16'h0000, 3'b000};
      vecs[6]  = '{1'b1, 4'd7,  32'h0000_0077, 1'b1, 4'd7, 4'd7,  4'd5,  4'd7,
                   32'h0000_0077, 32'h0000_0055, 32'h0000_0077, 16'h0080, 3'b101};
      vecs[7]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd7, 4'd7,  4'd2,  4'd7,
                   32'h0000_0077, 32'h0,         32'h0000_0077, 16'h0080, 3'b101};
      vecs[8]  = '{1'b1, 4'd2,  32'h0000_0022, 1'b1, 4'd9, 4'd2,  4'd9,  4'd7,
                   32'h0000_0022, 32'h0,         32'h0000_0077, 16'h0280, 3'b110};
      vecs[9]  = '{1'b1, 4'd9,  32'h0000_0099, 1'b1, 4'd2, 4'd9,  4'd2,  4'd15,
                   32'h0000_0099, 32'h0000_0022, 32'h0,         16'h0084, 3'b010};
      vecs[10] = '{1'b1, 4'd7,  32'h0000_7777, 1'b0, 4'd0, 4'd7,  4'd2,  4'd9,
                   32'h0000_7777, 32'h0000_0022, 32'h0000_0099, 16'h0004, 3'b010};

      RESET = 1'b1;
      pw = '0; rw = '0; le = 1'b0; raddr = '0; pc_ld = 1'b0; pc_in = '0; pc_en = 1'b0;
      rsv_en = 1'b0; rsv_addr = '0;
      b_pw = '0; b_rw = '0; b_le = 1'b0; b_raddr = '0; b_pc_ld = 1'b0; b_pc_in = '0;
      b_pc_en = 1'b0; b_rsv_en = 1'b0; b_rsv_addr = '0;

      #12;
      RESET = 1'b0;
      set_ra(0, 15);
      set_ra(1, 3);
      #1;
      check("rst_pc", 64'(pc), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_rd_pc_idx", 64'(rdata[31:0]), 64'h0);
      check("rst_rd_r3", 64'(rdata[63:32]), 64'h0);
      check("rst_b_pc", 64'(b_pc), 64'h0);

      for (int i = 1; i <= 3; i++) begin
         pc_en = 1'b1;
         push(S_PC, $sformatf("pc_inc%0d", i), 64'(4 * i));
         cycle();
      end
      pc_ld = 1'b1; pc_in = 32'h100; pc_en = 1'b1;
      push(S_PC, "pc_ld_over_en", 64'h100);
      cycle();
      le = 1'b1; rw = 4'd15; pw = 32'h200; pc_en = 1'b1; set_ra(1, 15);
      push(S_PC, "pc_wr_over_en", 64'h200);
      push(S_RD1, "rd_pc_idx", 64'h200);
      cycle();
      pc_ld = 1'b1; pc_in = 32'h300; le = 1'b1; rw = 4'd15; pw = 32'h400;
      push(S_PC, "pc_ld_over_wr", 64'h300);
      cycle();
      pc_en = 1'b1;
      push(S_PC, "pc_inc_after_ld", 64'h304);
      cycle();
      push(S_PC, "pc_hold", 64'h304);
      cycle();
      pc_ld = 1'b1; pc_in = 32'hFFFF_FFFC;
      push(S_PC, "pc_ld_top", 64'hFFFF_FFFC);
      cycle();
      pc_en = 1'b1;
      push(S_PC, "pc_wrap", 64'h0);
      push(S_RD1, "rd_pc_wrap", 64'h0);
      cycle();

      le = 1'b1; rw = 4'd3; pw = 32'hDEAD_BEEF; set_ra(0, 3); set_ra(2, 3);
      #1;
      exp_pre = BYPASS ? 32'hDEAD_BEEF : 32'h0;
      check("wr_pre_edge_p0", 64'(rdata[31:0]), 64'(exp_pre));
      check("wr_pre_edge_p2", 64'(rdata[95:64]), 64'(exp_pre));
      push(S_RD0, "wr_post_edge_p0", 64'hDEAD_BEEF);
      push(S_RD2, "wr_post_edge_p2", 64'hDEAD_BEEF);
      cycle();

      for (int i = 0; i < 11; i++) begin
         le = vecs[i].le; rw = vecs[i].rw; pw = vecs[i].pw;
         rsv_en = vecs[i].rsv; rsv_addr = vecs[i].rsv_a;
         set_ra(0, int'(vecs[i].ra0));
         set_ra(1, int'(vecs[i].ra1));
         set_ra(2, int'(vecs[i].ra2));
         push(S_RD0,   $sformatf("vec%0d_rd0", i),   64'(vecs[i].e0));
         push(S_RD1,   $sformatf("vec%0d_rd1", i),   64'(vecs[i].e1));
         push(S_RD2,   $sformatf("vec%0d_rd2", i),   64'(vecs[i].e2));
         push(S_BUSY,  $sformatf("vec%0d_busy", i),  64'(vecs[i].ebusy));
         push(S_RBUSY, $sformatf("vec%0d_rbusy", i), 64'(vecs[i].erbusy));
         cycle();
      end

      b_le = 1'b1; b_rw = 3'd6; b_pw = 16'h1234; b_raddr = {3'd6, 3'd7};
      push(S_B_RD1, "b_wr_r6_p1", 64'h1234);
      push(S_B_RD0, "b_rd_pc_idx", 64'h0);
      cycle();
      b_pc_ld = 1'b1; b_pc_in = 16'hFFF8;
      push(S_B_PC, "b_pc_ld", 64'hFFF8);
      push(S_B_RD0, "b_rd_pc_ld", 64'hFFF8);
      cycle();
      b_pc_en = 1'b1;
      push(S_B_PC, "b_pc_inc", 64'hFFFC);
      cycle();
      b_pc_en = 1'b1; b_rsv_en = 1'b1; b_rsv_addr = 3'd3;
      push(S_B_PC, "b_pc_wrap", 64'h0);
      push(S_B_RD0, "b_rd_pc_wrap", 64'h0);
      push(S_B_BUSY, "b_busy_rsv3", 64'h08);
      push(S_B_RD1, "b_r6_hold", 64'h1234);
      cycle();

      pc_ld = 1'b1; pc_in = 32'h40; rsv_en = 1'b1; rsv_addr = 4'd11;
      push(S_PC, "pre_rst_pc", 64'h40);
      push(S_BUSY, "pre_rst_busy", 64'h0804);
      cycle();
      #2;
      le = 1'b1; rw = 4'd15; pw = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd6; pc_en = 1'b1;
      RESET = 1'b1;
      #1;
      check("async_rst_pc", 64'(pc), 64'h0);
      check("async_rst_busy", 64'(busy), 64'h0);
      check("async_rst_b_busy", 64'(b_busy), 64'h0);
      for (int a = 0; a < 15; a++) begin
         set_ra(0, a);
         set_ra(2, 14 - a);
         #1;
         check($sformatf("rst_rd_p0_r%0d", a), 64'(rdata[31:0]), 64'h0);
         check($sformatf("rst_rd_p2_r%0d", 14 - a), 64'(rdata[95:64]), 64'h0);
      end
      @(posedge CLK);
      #1;
      check("rst_override_pc", 64'(pc), 64'h0);
      check("rst_override_busy", 64'(busy), 64'h0);
      check("rst_b_r6", 64'(b_rdata[31:16]), 64'h0);
      @(negedge CLK);
      RESET = 1'b0;
      le = 1'b0; rsv_en = 1'b0; pc_en = 1'b0;
      pc_en = 1'b1;
      push(S_PC, "post_rst_pc_inc", 64'h4);
      push(S_BUSY, "post_rst_busy", 64'h0);
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 16x32 three-read-port register file.
- Provides NUM_REGS registers of DATA_W bits with NUM_RD combinational read ports and one synchronous write port.
- The top register is an internal program counter with load and auto-increment.
- A per-register busy scoreboard lets the pipeline detect pending writes. The block sits between the decode and writeback stages of the ARM datapath.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, total registers including PC; power of two, minimum 4; AW = clog2(NUM_REGS).
- NUM_RD, 3, number of read ports; minimum 1.
- PC_STEP, 4, amount added to PC on each increment.
- PC_RESET, 0, PC value after reset.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PW  in  DATA_W  write data.
- RW  in  AW  write address.
- LE  in  1  write enable.
- RADDR  in  NUM_RD*AW  read addresses; port k uses slice [k*AW +: AW].
- RDATA  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W].
- RBUSY  out  NUM_RD  busy flag of the register addressed by each read port.
- PC_LD  in  1  load PC from PC_IN.
- PC_IN  in  DATA_W  PC load value.
- PC_EN  in  1  increment PC by PC_STEP.
- PC  out  DATA_W  current PC value.
- RSV_EN  in  1  reserve a register, marking it busy.
- RSV_ADDR  in  AW  register to reserve.
- BUSY  out  NUM_REGS  full scoreboard vector.

Behaviour:
- Reset, asynchronous, on RESET high:
  - Registers 0..NUM_REGS-2 are cleared to 0.
  - PC is set to PC_RESET.
  - BUSY is cleared to all zeros.
  - Outputs take these values immediately, without waiting for a clock edge.
- General write:
  - On a rising edge with LE=1 and RW < NUM_REGS-1, register[RW] <= PW.
  - Latency is one edge; the new value is visible on RDATA after that edge.
  - There is no intermediate write-enable pipeline stage.
- PC update priority, per edge, highest first:
  1. PC_LD: PC <= PC_IN.
  2. LE=1 and RW = NUM_REGS-1: PC <= PW.
  3. PC_EN: PC <= PC + PC_STEP, wrapping modulo 2^DATA_W.
  4. Otherwise PC holds its value.
- Read ports:
  - Purely combinational: RDATA[k] = register[RADDR[k]].
  - Address NUM_REGS-1 returns the current PC value.
  - RBUSY[k] = BUSY[RADDR[k]].
- Scoreboard, per register i, on each edge:
  - If RSV_EN and RSV_ADDR = i, BUSY[i] <= 1.
  - Else if LE and RW = i, BUSY[i] <= 0.
  - Else BUSY[i] holds.
  - When a reserve and a write hit the same register in the same cycle, the reserve wins: the new instruction's write is still pending.
  - A reserve of an already-busy register keeps it busy.
  - A write to a non-busy register leaves its busy bit 0.
- No state machine beyond the registers, PC and scoreboard; all outputs follow from this state.
- Reset asserted mid-operation overrides any write, reserve or PC action in that cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read port k with LE=1 and RADDR[k] = RW returns PW combinationally in the same cycle. This applies to the PC index as well, where PW is returned even if PC_LD is also asserted. RBUSY[k] reads 0 for a bypassed port.
- Undefined: reads always return stored state; the written value appears only after the edge.

Test Plan:
- Reset: assert RESET async mid-cycle with PC=0x40 -> PC=0 and BUSY=0 immediately; all RDATA=0 for addresses 0..14.
- Write/read: LE=1, RW=3, PW=0xDEADBEEF for one edge; RADDR port0=3, port2=3 -> both read 0xDEADBEEF after the edge and 0 before it. Repeat with REGFILE_BYPASS_EN defined -> same-cycle read returns 0xDEADBEEF.
- PC: PC_EN=1 for 3 edges from reset -> PC=0x0C. Next, PC_LD=1, PC_IN=0x100 with PC_EN=1 -> PC=0x100. Then LE=1, RW=15, PW=0x200 with PC_EN=1 -> PC=0x200. Then PC=0xFFFFFFFC with PC_EN -> PC=0.
- Scoreboard: RSV_EN, RSV_ADDR=5 -> BUSY[5]=1 and RBUSY=1 on a port reading 5. Next, LE, RW=5 -> BUSY[5]=0. Then RSV_EN and LE both on register 7 in the same cycle -> BUSY[7]=1.
- Parameter sweep: DATA_W=16, NUM_REGS=8, NUM_RD=2 -> write 0x1234 to r6, read it on port1. Reading address 7 returns PC, and PC increments by PC_STEP modulo 2^16.
